// File: rtl/neighbour_pattern_gen.sv
// neighbour_pattern_gen
// Walks an 8-bit candidate from 8'h00 to 8'hFF and presents every value whose
// live-cell count equals the latched target on a valid/ready handshake. It
// drives the same eight neighbour signals that the rule detectors consume, so
// it can serve as stimulus and self-test for them.
// Pattern vector ordering: {l,la,a,ra,r,rb,b,lb}, with l as the MSB.

module neighbour_pattern_gen #(
    parameter int CNT_W       = 7,
    parameter bit ALLOW_ABORT = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       target,
    input  logic             abort,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             l,
    output logic             la,
    output logic             a,
    output logic             ra,
    output logic             r,
    output logic             rb,
    output logic             b,
    output logic             lb,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        PRESENT,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] cand;
    logic [7:0] pattern;
    logic [3:0] tgt;
    logic [3:0] cand_ones;
    logic       abort_en;

    // Counts the live cells in one neighbourhood.
    // A count above 8 cannot occur, so a target of 9..15 never matches.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    assign cand_ones = popcount8(cand);
    assign abort_en  = ALLOW_ABORT & abort;

    assign {l, la, a, ra, r, rb, b, lb} = pattern;

    // Run controller: every output is a register updated here.
    // Entering DONE raises done and drops busy together, so the done pulse
    // lines up exactly with the single cycle spent in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cand      <= 8'd0;
            tgt       <= 4'd0;
            pattern   <= 8'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        tgt   <= target;
                        cand  <= 8'd0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= SEARCH;
                    end
                end

                SEARCH: begin
                    if (abort_en) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (cand_ones == tgt) begin
                        pattern   <= cand;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end else if (cand == 8'hFF) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cand <= cand + 8'd1;
                    end
                end

                PRESENT: begin
                    // A pattern accepted in the same cycle as an abort
                    // still counts; the abort only decides where we go next.
                    if (out_ready) begin
                        count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                    if (abort_en) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cand == 8'hFF) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cand  <= cand + 8'd1;
                            state <= SEARCH;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
